p_hit_num_den: RTL and testbench

Parametrised successor to the first ray/plane hit stage. For each ray it computes the fixed-point plane-intersection numerator num = N·(v0 − origin) and denominator den = N·dir. It also classifies the ray as a miss (parallel, behind origin, or culled back-face). Results are buffered in an internal first-word-fall-through FIFO. The block sits between the ray-source FIFO and the divider stage that forms t = num/den.

---
 rtl/p_hit_num_den_if.sv | 29 ++
 rtl/p_hit_num_den.sv | 148 ++++++++++++++
 tb/tb_p_hit_num_den.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p_hit_num_den_if.sv
// Ray-in / result-out bundle for the plane-hit numerator/denominator stage.
// master: ray source + result consumer side; slave: the hit stage itself.
// Vectors are packed [2:0] = (z, y, x) so index 0 is the x component.
interface p_hit_num_den_if #(
  parameter int DATA_W = 32
);
  logic [2:0][DATA_W-1:0] tri_normal;
  logic [2:0][DATA_W-1:0] v0;
  logic [2:0][DATA_W-1:0] origin;
  logic [2:0][DATA_W-1:0] dir;
  logic                   in_wr_en;
  logic                   in_full;
  logic [DATA_W-1:0]      out_num;
  logic [DATA_W-1:0]      out_den;
  logic                   out_miss;
  logic                   out_empty;
  logic                   out_rd_en;
  logic                   overflow_err;

  modport master (
    output tri_normal, v0, origin, dir, in_wr_en, out_rd_en,
    input  in_full, out_num, out_den, out_miss, out_empty, overflow_err
  );

  modport slave (
    input  tri_normal, v0, origin, dir, in_wr_en, out_rd_en,
    output in_full, out_num, out_den, out_miss, out_empty, overflow_err
  );
endinterface

// File: rtl/p_hit_num_den.sv
// Ray/plane hit stage: num = N.(v0-origin), den = N.dir, plus miss classification, into an FWFT FIFO.
// Latency: ray accepted at edge k is visible at the FIFO head after edge k+3.
// Backpressure: in_full is a credit check (fifo_count + in-flight >= depth); writes while full are dropped and flag overflow_err.
// Ports: clock, reset (async active-low), bus (slave view of p_hit_num_den_if: ray inputs,
//        in_wr_en/in_full, out_num/out_den/out_miss/out_empty/out_rd_en, sticky overflow_err).
module p_hit_num_den #(
  parameter int DATA_W        = 32,
  parameter int Q_BITS        = 16,
  parameter int FIFO_DEPTH    = 8,   // power of 2, >= 4
  parameter int BACKFACE_CULL = 0
) (
  input logic              clock,
  input logic              reset,
  p_hit_num_den_if.slave   bus
);

  localparam int DW1 = DATA_W + 1;       // v0 - origin without overflow
  localparam int PW  = 2 * DATA_W + 1;   // full-precision product
  localparam int SW  = PW + 2;           // triple sum with 2 guard bits
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  // ---------------- pipeline state ----------------
  logic                     s1_vld, s2_vld, s3_vld;
  logic signed [DW1-1:0]    s1_diff [3];
  logic signed [DATA_W-1:0] s1_dir  [3];
  logic signed [DATA_W-1:0] s1_n    [3];
  logic signed [PW-1:0]     s2_pn   [3];
  logic signed [PW-1:0]     s2_pd   [3];
  logic signed [SW-1:0]     s3_num, s3_den;

  // ---------------- FIFO state ----------------
  logic [DATA_W-1:0]     mem_num [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_den [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_miss;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic                  ovf_q;

  logic        [1:0]     inflight;
  logic        [CW:0]    occupancy;
  logic                  full, empty, accept, wr_fire, rd_fire;
  logic signed [SW-1:0]  sh_num, sh_den;
  logic [DATA_W-1:0]     wr_num, wr_den;
  logic                  wr_den_zero, wr_miss;

  // Credits: every ray already in S1..S3 has a FIFO slot reserved, so the
  // S3 write never needs a full check of its own.
  assign inflight  = {1'b0, s1_vld} + {1'b0, s2_vld} + {1'b0, s3_vld};
  assign occupancy = {1'b0, fifo_cnt} + (CW+1)'(inflight);
  assign full      = occupancy >= (CW+1)'(FIFO_DEPTH);
  assign empty     = (fifo_cnt == '0);
  assign accept    = bus.in_wr_en & ~full;
  assign wr_fire   = s3_vld;
  assign rd_fire   = bus.out_rd_en & ~empty;

  // ---------------- valid chain ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  // ---------------- datapath (no reset needed, qualified by valids) ----------------
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        s1_diff[i] <= DW1'($signed(bus.v0[i])) - DW1'($signed(bus.origin[i]));
        s1_dir[i]  <= $signed(bus.dir[i]);
        s1_n[i]    <= $signed(bus.tri_normal[i]);
      end
    end
    if (s1_vld) begin
      for (int i = 0; i < 3; i++) begin
        s2_pn[i] <= PW'(s1_n[i]) * PW'(s1_diff[i]);
        s2_pd[i] <= PW'(s1_n[i]) * PW'(s1_dir[i]);
      end
    end
    if (s2_vld) begin
      s3_num <= SW'(s2_pn[0]) + SW'(s2_pn[1]) + SW'(s2_pn[2]);
      s3_den <= SW'(s2_pd[0]) + SW'(s2_pd[1]) + SW'(s2_pd[2]);
    end
  end

  // Clamp to DATA_W: any bit above the result MSB disagreeing with the sign
  // means the value is out of range.
  function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
    if (x[SW-1] && !(&x[SW-1:DATA_W-1]))
      return {1'b1, {(DATA_W-1){1'b0}}};
    else if (!x[SW-1] && (|x[SW-1:DATA_W-1]))
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return x[DATA_W-1:0];
  endfunction

  // Arithmetic shift floors toward -inf, as required for negative results.
  assign sh_num      = s3_num >>> Q_BITS;
  assign sh_den      = s3_den >>> Q_BITS;
  assign wr_num      = sat(sh_num);
  assign wr_den      = sat(sh_den);
  assign wr_den_zero = (wr_den == '0);
  // Miss: parallel ray, hit behind origin (t < 0), or culled back-face.
  assign wr_miss = wr_den_zero
                 | ((wr_num != '0) && (wr_num[DATA_W-1] != wr_den[DATA_W-1]))
                 | ((BACKFACE_CULL != 0) && !wr_den[DATA_W-1] && !wr_den_zero);

  // ---------------- output FIFO ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_fire, rd_fire})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (bus.in_wr_en && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_num[wr_ptr]  <= wr_num;
      mem_den[wr_ptr]  <= wr_den;
      mem_miss[wr_ptr] <= wr_miss;
    end
  end

  // Head entry is forced to zero when empty so stale RAM never leaks out.
  assign bus.out_num      = empty ? '0   : mem_num[rd_ptr];
  assign bus.out_den      = empty ? '0   : mem_den[rd_ptr];
  assign bus.out_miss     = empty ? 1'b0 : mem_miss[rd_ptr];
  assign bus.out_empty    = empty;
  assign bus.in_full      = full;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_p_hit_num_den.sv
module tb_p_hit_num_den;

  typedef struct {
    logic [31:0] num;
    logic [31:0] den;
    logic        miss;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  p_hit_num_den_if #(.DATA_W(32)) a_if ();
  p_hit_num_den_if #(.DATA_W(32)) b_if ();

  // a: default depth, no culling.  b: minimum depth with culling.
  p_hit_num_den #(.DATA_W(32), .Q_BITS(16), .FIFO_DEPTH(8), .BACKFACE_CULL(0))
    u_a (.clock(clock), .reset(reset), .bus(a_if.slave));
  p_hit_num_den #(.DATA_W(32), .Q_BITS(16), .FIFO_DEPTH(4), .BACKFACE_CULL(1))
    u_b (.clock(clock), .reset(reset), .bus(b_if.slave));

  int   checks = 0;
  int   failures = 0;
  res_t q_a[$];
  res_t q_b[$];
  bit   a_rd_all = 0, a_rd_req = 0, b_rd_req = 0;
  bit   a_ovf_exp = 0, b_ovf_exp = 0;
  int   a_acc = 0, b_acc = 0, a_full_seen = 0;

  assign a_if.out_rd_en = a_rd_all ? !a_if.out_empty : a_rd_req;
  assign b_if.out_rd_en = b_rd_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: exact wide integer dot products, floor division by 2^16, clamp.
  function automatic logic [31:0] clamp(input logic signed [127:0] x);
    if (x > 128'sd2147483647)  return 32'h7FFF_FFFF;
    if (x < -128'sd2147483648) return 32'h8000_0000;
    return x[31:0];
  endfunction

  function automatic res_t model(input logic [2:0][31:0] n, v, o, d, input bit cull);
    logic signed [127:0] sn, sd, a, b, c, e;
    res_t r;
    sn = 0;
    sd = 0;
    for (int i = 0; i < 3; i++) begin
      a = $signed(n[i]);
      b = $signed(v[i]);
      c = $signed(o[i]);
      e = $signed(d[i]);
      sn = sn + a * (b - c);
      sd = sd + a * e;
    end
    sn = sn >>> 16;
    sd = sd >>> 16;
    r.num  = clamp(sn);
    r.den  = clamp(sd);
    r.miss = (r.den == 0) || (r.num != 0 && r.num[31] != r.den[31]) ||
             (cull && $signed(r.den) > 0);
    return r;
  endfunction

  function automatic logic [2:0][31:0] vec(input logic [31:0] x, y, z);
    return {z, y, x};
  endfunction

  function automatic logic [31:0] rnd_comp();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'h0;
      2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
    endcase
  endfunction

  function automatic logic [2:0][31:0] rnd_vec();
    return vec(rnd_comp(), rnd_comp(), rnd_comp());
  endfunction

  // One clock of stimulus; acceptance is judged from in_full mid-cycle.
  task automatic cyc_a(input bit wr);
    a_if.in_wr_en = wr;
    @(negedge clock);
    if (wr && a_if.in_full) a_ovf_exp = 1;
    if (wr && !a_if.in_full) begin
      q_a.push_back(model(a_if.tri_normal, a_if.v0, a_if.origin, a_if.dir, 1'b0));
      a_acc++;
    end
    if (a_rd_all && a_if.in_full) a_full_seen++;
    @(posedge clock);
    #1;
  endtask

  task automatic cyc_b(input bit wr);
    b_if.in_wr_en = wr;
    @(negedge clock);
    if (wr && b_if.in_full) b_ovf_exp = 1;
    if (wr && !b_if.in_full) begin
      q_b.push_back(model(b_if.tri_normal, b_if.v0, b_if.origin, b_if.dir, 1'b1));
      b_acc++;
    end
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: compare every entry actually popped.
  always @(negedge clock) begin : mon_a
    res_t e;
    if (reset && !a_if.out_empty && a_if.out_rd_en) begin
      if (q_a.size() == 0) chk("a_unexpected_entry", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_num", a_if.out_num, e.num);
        chk("a_den", a_if.out_den, e.den);
        chk("a_miss", 32'(a_if.out_miss), 32'(e.miss));
      end
    end
  end

  always @(negedge clock) begin : mon_b
    res_t e;
    if (reset && !b_if.out_empty && b_if.out_rd_en) begin
      if (q_b.size() == 0) chk("b_unexpected_entry", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_num", b_if.out_num, e.num);
        chk("b_den", b_if.out_den, e.den);
        chk("b_miss", 32'(b_if.out_miss), 32'(e.miss));
      end
    end
  end

  // Single directed ray on a: latency, constant results, then pop.
  task automatic dir_a(input string name, input logic [2:0][31:0] n, v, o, d,
                       input logic [31:0] en, ed, input logic em);
    a_if.tri_normal = n;
    a_if.v0         = v;
    a_if.origin     = o;
    a_if.dir        = d;
    cyc_a(1);
    cyc_a(0);
    chk({name, "_empty_k1"}, 32'(a_if.out_empty), 32'd1);
    cyc_a(0);
    chk({name, "_empty_k2"}, 32'(a_if.out_empty), 32'd1);
    cyc_a(0);
    chk({name, "_empty_k3"}, 32'(a_if.out_empty), 32'd0);
    chk({name, "_num"}, a_if.out_num, en);
    chk({name, "_den"}, a_if.out_den, ed);
    chk({name, "_miss"}, 32'(a_if.out_miss), 32'(em));
    a_rd_req = 1;
    cyc_a(0);
    a_rd_req = 0;
    chk({name, "_empty_after_pop"}, 32'(a_if.out_empty), 32'd1);
  endtask

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || !a_if.out_empty) && n < 30) begin
      cyc_a(0);
      n++;
    end
    chk({name, "_drained"}, 32'(q_a.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_full"},  32'(a_if.in_full),      32'd0);
    chk({name, "_empty"}, 32'(a_if.out_empty),    32'd1);
    chk({name, "_num"},   a_if.out_num,           32'd0);
    chk({name, "_den"},   a_if.out_den,           32'd0);
    chk({name, "_miss"},  32'(a_if.out_miss),     32'd0);
    chk({name, "_ovf"},   32'(a_if.overflow_err), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc0;
    a_if.in_wr_en = 0; b_if.in_wr_en = 0;
    a_if.tri_normal = '0; a_if.v0 = '0; a_if.origin = '0; a_if.dir = '0;
    b_if.tri_normal = '0; b_if.v0 = '0; b_if.origin = '0; b_if.dir = '0;

    repeat (2) @(posedge clock);
    #1;
    chk_idle_outputs("in_reset");
    reset = 1;
    @(posedge clock);
    #1;
    chk_idle_outputs("after_reset");
    chk("b_ovf_after_reset", 32'(b_if.overflow_err), 32'd0);

    // Directed vectors (x, y, z)
    dir_a("basic", vec(0, 0, 32'h10000), vec(0, 0, 32'h50000), vec(0, 0, 0),
          vec(0, 0, 32'h10000), 32'h0005_0000, 32'h0001_0000, 1'b0);
    dir_a("parallel", vec(0, 0, 32'h10000), vec(0, 0, 32'h50000), vec(0, 0, 0),
          vec(32'h10000, 0, 0), 32'h0005_0000, 32'h0, 1'b1);
    dir_a("behind", vec(0, 0, 32'h10000), vec(0, 0, 32'h50000), vec(0, 0, 0),
          vec(0, 0, 32'hFFFF_0000), 32'h0005_0000, 32'hFFFF_0000, 1'b1);
    dir_a("sat_pos", vec(0, 0, 32'h7FFF_FFFF), vec(0, 0, 32'h7FFF_FFFF), vec(0, 0, 32'h8000_0000),
          vec(0, 0, 32'h10000), 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    dir_a("sat_neg", vec(0, 0, 32'h8000_0001), vec(0, 0, 32'h7FFF_FFFF), vec(0, 0, 32'h8000_0000),
          vec(0, 0, 32'h10000), 32'h8000_0000, 32'h8000_0001, 1'b0);
    dir_a("floor", vec(0, 0, 32'h1), vec(0, 0, 32'hFFFF_FFFF), vec(0, 0, 0),
          vec(0, 0, 32'h10000), 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

    // Back-face culling on b: the basic hit becomes a miss
    b_if.tri_normal = vec(0, 0, 32'h10000);
    b_if.v0         = vec(0, 0, 32'h50000);
    b_if.origin     = vec(0, 0, 0);
    b_if.dir        = vec(0, 0, 32'h10000);
    cyc_b(1);
    repeat (3) cyc_b(0);
    chk("cull_num", b_if.out_num, 32'h0005_0000);
    chk("cull_miss", 32'(b_if.out_miss), 32'd1);
    b_rd_req = 1;
    cyc_b(0);
    b_rd_req = 0;

    // Backpressure on b (depth 4): 8 back-to-back writes, no reads
    b_acc = 0;
    b_if.tri_normal = rnd_vec();
    b_if.v0 = rnd_vec();
    for (int i = 0; i < 8; i++) begin
      b_if.origin = rnd_vec();
      b_if.dir    = rnd_vec();
      cyc_b(1);
      if (i == 3) begin
        chk("bp_full_after_4", 32'(b_if.in_full), 32'd1);
        chk("bp_ovf_before_5", 32'(b_if.overflow_err), 32'd0);
      end
      if (i == 4) chk("bp_ovf_after_5", 32'(b_if.overflow_err), 32'd1);
    end
    repeat (3) cyc_b(0);
    chk("bp_accepted", 32'(b_acc), 32'd4);
    chk("bp_ovf_model", 32'(b_if.overflow_err), 32'(b_ovf_exp));
    b_rd_req = 1;
    repeat (4) cyc_b(0);
    b_rd_req = 0;
    chk("bp_empty_after_pops", 32'(b_if.out_empty), 32'd1);
    chk("bp_queue_drained", 32'(q_b.size()), 32'd0);
    chk("bp_ovf_sticky", 32'(b_if.overflow_err), 32'd1);
    chk("bp_read_empty_ignored_full", 32'(b_if.in_full), 32'd0);

    // Streaming on a: write every cycle, read whenever non-empty
    a_rd_all = 1;
    acc0 = a_acc;
    for (int blk = 0; blk < 4; blk++) begin
      a_if.tri_normal = rnd_vec();
      a_if.v0         = rnd_vec();
      for (int r = 0; r < 25; r++) begin
        a_if.origin = rnd_vec();
        a_if.dir    = rnd_vec();
        cyc_a(1);
      end
      drain_a("stream_blk");
    end
    a_rd_all = 0;
    chk("stream_accepted", 32'(a_acc - acc0), 32'd100);
    chk("stream_never_full", 32'(a_full_seen), 32'd0);
    chk("stream_ovf", 32'(a_if.overflow_err), 32'(a_ovf_exp));

    // Reset mid-stream: 3 buffered + 2 in flight, then asynchronous reset
    a_if.tri_normal = rnd_vec();
    a_if.v0         = rnd_vec();
    for (int r = 0; r < 5; r++) begin
      a_if.origin = rnd_vec();
      a_if.dir    = rnd_vec();
      cyc_a(1);
    end
    cyc_a(0);
    chk("pre_reset_not_empty", 32'(a_if.out_empty), 32'd0);
    #2;
    reset = 0;
    #1;
    chk_idle_outputs("mid_reset");
    chk("b_ovf_cleared", 32'(b_if.overflow_err), 32'd0);
    q_a.delete();
    q_b.delete();
    a_ovf_exp = 0;
    b_ovf_exp = 0;
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    a_if.origin = rnd_vec();
    a_if.dir    = rnd_vec();
    cyc_a(1);
    repeat (3) cyc_a(0);
    chk("post_reset_entry", 32'(a_if.out_empty), 32'd0);
    a_rd_req = 1;
    cyc_a(0);
    a_rd_req = 0;
    chk("post_reset_only_entry", 32'(a_if.out_empty), 32'd1);
    chk("post_reset_queue", 32'(q_a.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
